// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
//   fetch_state_t : FSM encoding (IDLE -> READ -> CAPTURE -> HOLD -> IDLE)
//   D_DEF         : default PC / ROM address width
//   W_DEF         : default instruction word width
//   CW_DEF        : default width of the saturating handshake counter
package fetch_pkg;

  localparam int D_DEF  = 12;
  localparam int W_DEF  = 9;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage between the program counter and the decoder.
// Issues one synchronous ROM read per new PC value, captures the word and
// offers it to the decoder until it is accepted.
//
// Ports:
//   clk          clock, all state changes on posedge
//   reset        asynchronous active-low reset
//   prog_ctr     current PC from the program counter stage
//   flush        synchronous discard of in-flight / held instruction
//   rom_data     ROM read data, valid the cycle after rom_en
//   instr_ready  decoder accepts instr this cycle
//   rom_en       ROM read strobe (high only in READ)
//   rom_addr     ROM read address
//   instr        fetched instruction word
//   instr_pc     PC the held instruction came from
//   instr_valid  instr / instr_pc are valid
//   fetch_count  completed handshakes, saturating at all-ones
//   state        current FSM state, exported for observation
//
// Handshake: a transfer happens on a rising clk edge where
// instr_valid & instr_ready are both high and flush is low. While
// instr_valid is high, instr and instr_pc do not change; instr_valid only
// drops after a transfer or a flush.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  prog_ctr,
  input  logic          flush,
  input  logic [W-1:0]  rom_data,
  input  logic          instr_ready,
  output logic          rom_en,
  output logic [D-1:0]  rom_addr,
  output logic [W-1:0]  instr,
  output logic [D-1:0]  instr_pc,
  output logic          instr_valid,
  output logic [CW-1:0] fetch_count,
  output fetch_state_t  state
);

  // Internal state
  logic [D-1:0] last_pc;
  logic         first;
  logic         pending;

  // Next-state values for every register
  fetch_state_t  nxt_state;
  logic [D-1:0]  nxt_last_pc;
  logic          nxt_first;
  logic          nxt_pending;
  logic          nxt_rom_en;
  logic [D-1:0]  nxt_rom_addr;
  logic [W-1:0]  nxt_instr;
  logic [D-1:0]  nxt_instr_pc;
  logic          nxt_instr_valid;
  logic [CW-1:0] nxt_fetch_count;

  logic pc_moved;
  logic trig;

  assign pc_moved = (prog_ctr != last_pc);
  // first forces the post-reset / post-flush fetch even when the PC matches
  assign trig     = first | pending | pc_moved;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_pc     <= '0;
      first       <= 1'b1;
      pending     <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= nxt_state;
      last_pc     <= nxt_last_pc;
      first       <= nxt_first;
      pending     <= nxt_pending;
      rom_en      <= nxt_rom_en;
      rom_addr    <= nxt_rom_addr;
      instr       <= nxt_instr;
      instr_pc    <= nxt_instr_pc;
      instr_valid <= nxt_instr_valid;
      fetch_count <= nxt_fetch_count;
    end
  end

  always_comb begin
    nxt_state       = state;
    nxt_last_pc     = last_pc;
    nxt_first       = first;
    nxt_pending     = pending;
    nxt_rom_en      = 1'b0;
    nxt_rom_addr    = rom_addr;
    nxt_instr       = instr;
    nxt_instr_pc    = instr_pc;
    nxt_instr_valid = instr_valid;
    nxt_fetch_count = fetch_count;

    if (flush) begin
      // Flush wins over everything, including a handshake in HOLD, which
      // is then not counted. Setting first refetches the current PC.
      nxt_state       = IDLE;
      nxt_instr_valid = 1'b0;
      nxt_first       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            nxt_state    = READ;
            nxt_last_pc  = prog_ctr;
            nxt_rom_addr = prog_ctr;
            nxt_first    = 1'b0;
            nxt_pending  = 1'b0;
            nxt_rom_en   = 1'b1;
          end
        end
        READ: begin
          nxt_state = CAPTURE;
          if (pc_moved) nxt_pending = 1'b1;
        end
        CAPTURE: begin
          nxt_state       = HOLD;
          nxt_instr       = rom_data;
          nxt_instr_pc    = last_pc;
          nxt_instr_valid = 1'b1;
          if (pc_moved) nxt_pending = 1'b1;
        end
        HOLD: begin
          if (pc_moved) nxt_pending = 1'b1;
          if (instr_ready) begin
            nxt_state       = IDLE;
            nxt_instr_valid = 1'b0;
            if (fetch_count != {CW{1'b1}}) begin
              nxt_fetch_count = fetch_count + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int D  = 12;
  localparam int W  = 9;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [D-1:0]  prog_ctr;
  logic          flush;
  logic [W-1:0]  rom_data;
  logic          instr_ready;
  logic          rom_en;
  logic [D-1:0]  rom_addr;
  logic [W-1:0]  instr;
  logic [D-1:0]  instr_pc;
  logic          instr_valid;
  logic [CW-1:0] fetch_count;
  fetch_state_t  state;

  // second instance with a 3-bit counter so saturation is reachable quickly
  logic          s_rom_en;
  logic [D-1:0]  s_rom_addr;
  logic [W-1:0]  s_instr;
  logic [D-1:0]  s_instr_pc;
  logic          s_instr_valid;
  logic [2:0]    s_fetch_count;
  fetch_state_t  s_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_count    = 0;

  logic [D-1:0] addr_q[$];

  instr_fetch #(.D(D), .W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .flush(flush),
    .rom_data(rom_data), .instr_ready(instr_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fetch_count(fetch_count), .state(state)
  );

  instr_fetch #(.D(D), .W(W), .CW(3)) dut_sat (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .flush(flush),
    .rom_data(rom_data), .instr_ready(instr_ready),
    .rom_en(s_rom_en), .rom_addr(s_rom_addr), .instr(s_instr),
    .instr_pc(s_instr_pc), .instr_valid(s_instr_valid),
    .fetch_count(s_fetch_count), .state(s_state)
  );

  // Hand-written ROM contents
  function automatic logic [W-1:0] rom_word(input logic [D-1:0] a);
    case (a)
      12'd0:   return 9'h1A5;
      12'd1:   return 9'h0C3;
      12'd2:   return 9'h15E;
      12'd5:   return 9'h07B;
      12'd6:   return 9'h1F0;
      12'd8:   return 9'h022;
      12'd9:   return 9'h134;
      default: return a[8:0] ^ 9'h0AA;
    endcase
  endfunction

  // synchronous ROM model
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  // record every ROM read issued
  always @(negedge clk) begin
    if (rom_en) addr_q.push_back(rom_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    tests_run++;
    if (instr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_wait_valid: instr_valid=%b after %0d cycles, required 1", tag, instr_valid, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; prog_ctr = '0; flush = 1'b0; instr_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({rom_en, rom_addr, instr, instr_pc, instr_valid, fetch_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: en=%b addr=%h instr=%h pc=%h v=%b cnt=%h, required all 0",
               rom_en, rom_addr, instr, instr_pc, instr_valid, fetch_count);
    end
    addr_q.delete();
    reset = 1'b1;
    tick();
    tests_run++;
    if (rom_en !== 1'b1 || rom_addr !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_first_read: rom_en=%b rom_addr=%h, required 1/000", rom_en, rom_addr);
    end
    tick();
    tests_run++;
    if (rom_en !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_capture: rom_en=%b valid=%b, required 0/0", rom_en, instr_valid);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 9'h1A5 || instr_pc !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_first_instr: valid=%b instr=%h pc=%h, required 1/1a5/000",
               instr_valid, instr, instr_pc);
    end
    tick();
    exp_count = 1;
    tests_run++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL reset_handshake: valid=%b count=%0d, required 0/1", instr_valid, fetch_count);
    end
  endtask

  task automatic test_step();
    prog_ctr = 12'd1;
    repeat (11) tick();
    prog_ctr = 12'd2;
    repeat (11) tick();
    exp_count = 3;
    tests_run++;
    if (addr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL step_read_count: %0d reads, required 3", addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (addr_q[i] !== D'(i)) begin
          tests_failed++;
          $display("FAIL step_addr%0d: %h, required %h", i, addr_q[i], D'(i));
        end
      end
    end
    tests_run++;
    if (fetch_count !== 16'd3 || instr !== 9'h15E || instr_pc !== 12'd2 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_final: count=%0d instr=%h pc=%h v=%b, required 3/15e/002/0",
               fetch_count, instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    instr_ready = 1'b0;
    prog_ctr = 12'd5;
    wait_valid("stall5");
    prog_ctr = 12'd6;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid !== 1'b1 || instr !== 9'h07B || instr_pc !== 12'd5 || rom_en !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_stable: %0d unstable cycles (instr=%h pc=%h v=%b), required 0",
               bad, instr, instr_pc, instr_valid);
    end
    instr_ready = 1'b1;
    tick();
    exp_count = 4;
    tests_run++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b count=%0d, required 0/4", instr_valid, fetch_count);
    end
    tick();
    tests_run++;
    if (rom_en !== 1'b1 || rom_addr !== 12'd6) begin
      tests_failed++;
      $display("FAIL stall_refetch: rom_en=%b addr=%h, required 1/006", rom_en, rom_addr);
    end
    wait_valid("stall6");
    tests_run++;
    if (instr !== 9'h1F0 || instr_pc !== 12'd6) begin
      tests_failed++;
      $display("FAIL stall_instr6: instr=%h pc=%h, required 1f0/006", instr, instr_pc);
    end
    tick();
    exp_count = 5;
    tests_run++;
    if (fetch_count !== 16'd5 || addr_q.size() != 5) begin
      tests_failed++;
      $display("FAIL stall_totals: count=%0d reads=%0d, required 5/5", fetch_count, addr_q.size());
    end
  endtask

  task automatic test_flush();
    instr_ready = 1'b0;
    prog_ctr = 12'd8;
    wait_valid("flush_pre");
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'd5 || rom_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: valid=%b count=%0d rom_en=%b, required 0/5/0",
               instr_valid, fetch_count, rom_en);
    end
    tick();
    tests_run++;
    if (rom_en !== 1'b1 || rom_addr !== 12'd8) begin
      tests_failed++;
      $display("FAIL flush_refetch: rom_en=%b addr=%h, required 1/008", rom_en, rom_addr);
    end
    wait_valid("flush_post");
    tests_run++;
    if (instr !== 9'h022 || instr_pc !== 12'd8) begin
      tests_failed++;
      $display("FAIL flush_instr: instr=%h pc=%h, required 022/008", instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    exp_count = 6;
    tests_run++;
    if (fetch_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL flush_count: %0d, required 6", fetch_count);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    prog_ctr = 12'd9;
    while (rom_en !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    tests_run++;
    if (rom_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_read: rom_en=%b, required 1", rom_en);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({rom_en, rom_addr, instr, instr_pc, instr_valid, fetch_count, s_fetch_count} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async: en=%b addr=%h instr=%h pc=%h v=%b cnt=%h scnt=%h, required all 0",
               rom_en, rom_addr, instr, instr_pc, instr_valid, fetch_count, s_fetch_count);
    end
    tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (rom_en !== 1'b1 || rom_addr !== 12'd9) begin
      tests_failed++;
      $display("FAIL midreset_restart: rom_en=%b addr=%h, required 1/009", rom_en, rom_addr);
    end
    wait_valid("midreset");
    tests_run++;
    if (instr !== 9'h134 || instr_pc !== 12'd9) begin
      tests_failed++;
      $display("FAIL midreset_instr: instr=%h pc=%h, required 134/009", instr, instr_pc);
    end
    tick();
    exp_count = 1;
    tests_run++;
    if (fetch_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL midreset_count: %0d, required 1", fetch_count);
    end
  endtask

  task automatic test_saturation();
    instr_ready = 1'b1;
    for (int pc = 20; pc < 28; pc++) begin
      prog_ctr = D'(pc);
      repeat (6) tick();
      exp_count++;
      tests_run++;
      if (fetch_count !== CW'(exp_count) ||
          s_fetch_count !== ((exp_count > 7) ? 3'd7 : 3'(exp_count))) begin
        tests_failed++;
        $display("FAIL sat_pc%0d: count=%0d small=%0d, required %0d/%0d", pc, fetch_count,
                 s_fetch_count, exp_count, (exp_count > 7) ? 7 : exp_count);
      end
    end
    tests_run++;
    if (instr_pc !== 12'd27 || instr !== rom_word(12'd27)) begin
      tests_failed++;
      $display("FAIL sat_last_instr: instr=%h pc=%h, required %h/01b", instr, instr_pc, rom_word(12'd27));
    end
  endtask

  initial begin
    rom_data = '0;
    test_reset();
    test_step();
    test_hold_stall();
    test_flush();
    test_reset_mid_read();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
